smc_seq: RTL and testbench

Sequential, parametrised successor of the combinational MOSFET calculator. It accepts transistor descriptors serially over a valid/ready handshake and computes a per-transistor drain current or transconductance. An insertion sorter keeps the results in order, and the block reports the (weighted) average of the top or bottom K results. It sits between the stimulus/input stage and the result checker in the lab datapath.

---
 rtl/smc_seq.sv | 177 +++++++++++++++++
 tb/tb_smc_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/smc_seq.sv
// smc_seq: serial MOSFET calculator. Accepts N_MOS descriptors, keeps their gm/current
// values in a descending insertion sorter, then averages the top or bottom K entries.
module smc_seq #(
    parameter int N_MOS = 6,
    parameter int K     = 3,
    parameter int DW    = 3,
    parameter int OW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] W,
    input  logic [DW-1:0] V_GS,
    input  logic [DW-1:0] V_DS,
    output logic          out_valid,
    output logic [OW-1:0] out_n
);

    localparam int VW = 3 * DW;
    localparam int PW = 3 * DW + 2;
    localparam int AW = VW + 4 + $clog2(K);
    localparam int QW = AW + OW;
    localparam int CW = $clog2(N_MOS + 1);
    localparam int IW = (N_MOS > 1) ? $clog2(N_MOS) : 1;
    localparam int JW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SUM, DIV, OUT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [CW-1:0]   count_q, count_d;
    logic [VW-1:0]   sort_q [N_MOS];
    logic [VW-1:0]   sort_d [N_MOS];
    logic [JW-1:0]   j_q, j_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [OW-1:0]   res_q, res_d;
    logic            out_valid_q, out_valid_d;
    logic [OW-1:0]   out_n_q, out_n_d;

    logic            accept;
    logic            beat_current;
    logic [DW-1:0]   vov;
    logic            triode;
    logic [PW-1:0]   vov_w, vds_w, mult, prod;
    logic [VW-1:0]   beat_value;
    logic [N_MOS-1:0] keep;
    logic [VW-1:0]   ins [N_MOS];
    logic [IW-1:0]   sel_idx;
    logic [VW-1:0]   sel_value;
    logic [AW-1:0]   term, q_div;
    logic [QW-1:0]   q_wide;
    logic [OW-1:0]   q_sat;

    assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_n     = out_n_q;

    // Per-beat value; the first beat of a frame uses the live mode, later beats the latched one.
    always_comb begin
        beat_current = (state_q == IDLE) ? mode[0] : mode_q[0];
        vov          = (V_GS == '0) ? '0 : V_GS - DW'(1);
        triode       = vov > V_DS;
        vov_w        = PW'(vov);
        vds_w        = PW'(V_DS);
        if (!beat_current)
            mult = triode ? (vds_w << 1) : (vov_w << 1);
        else
            mult = triode ? ((vov_w * vds_w) << 1) - (vds_w * vds_w) : (vov_w * vov_w);
        prod       = PW'(W) * mult;
        beat_value = VW'(prod / PW'(3));
    end

    // keep[] is a prefix of the valid entries that stay put; the new value lands right after it.
    always_comb begin
        for (int i = 0; i < N_MOS; i++)
            keep[i] = (CW'(i) < count_q) && (sort_q[i] >= beat_value);
        ins[0] = keep[0] ? sort_q[0] : beat_value;
        for (int i = 1; i < N_MOS; i++) begin
            if (keep[i])
                ins[i] = sort_q[i];
            else if (keep[i-1])
                ins[i] = beat_value;
            else
                ins[i] = sort_q[i-1];
        end
    end

    always_comb begin
        sel_idx   = mode_q[1] ? IW'(j_q) : IW'(N_MOS - K) + IW'(j_q);
        sel_value = sort_q[sel_idx];
        term      = mode_q[0] ? (AW'(j_q) + AW'(3)) * AW'(sel_value) : AW'(sel_value);
        q_div     = acc_q / AW'(K);
        if (mode_q[0])
            q_div = q_div >> 2;
        q_wide = QW'(q_div);
        q_sat  = (q_wide > QW'({OW{1'b1}})) ? '1 : OW'(q_div);
    end

    // NOTE: every *_d gets its hold value first, so no branch below can leave one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        count_d     = count_q;
        sort_d      = sort_q;
        j_d         = j_q;
        acc_d       = acc_q;
        res_d       = res_q;
        out_valid_d = 1'b0;
        out_n_d     = out_n_q;
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    if (state_q == IDLE)
                        mode_d = mode;
                    sort_d  = ins;
                    count_d = count_q + CW'(1);
                    if (count_q + CW'(1) == CW'(N_MOS)) begin
                        state_d = SUM;
                        j_d     = '0;
                        acc_d   = '0;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            SUM: begin
                acc_d = acc_q + term;
                j_d   = j_q + JW'(1);
                if (j_q == JW'(K - 1))
                    state_d = DIV;
            end
            DIV: begin
                res_d   = q_sat;
                state_d = OUT;
            end
            OUT: begin
                out_valid_d = 1'b1;
                out_n_d     = res_q;
                count_d     = '0;
                for (int i = 0; i < N_MOS; i++)
                    sort_d[i] = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the sorter array is reset explicitly; a discarded partial frame must not leak into the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            count_q     <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
            for (int i = 0; i < N_MOS; i++)
                sort_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            count_q     <= count_d;
            j_q         <= j_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            out_n_q     <= out_n_d;
            sort_q      <= sort_d;
        end
    end

endmodule

// File: tb/tb_smc_seq.sv
// Directed self-checking bench for smc_seq: default instance plus an OW=6 instance
// sharing the same stimulus for the saturation case.
`timescale 1ns/1ps
module tb_smc_seq;

    localparam int N_MOS = 6;
    localparam int K     = 3;
    localparam int DW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [1:0]    mode;
    logic [DW-1:0] w, v_gs, v_ds;
    logic          in_ready, out_valid;
    logic [7:0]    out_n;
    logic          sat_in_ready, sat_out_valid;
    logic [5:0]    sat_out_n;

    logic [DW-1:0] fw [N_MOS];
    logic [DW-1:0] fg [N_MOS];
    logic [DW-1:0] fd [N_MOS];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    smc_seq #(.N_MOS(N_MOS), .K(K), .DW(DW), .OW(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .W(w), .V_GS(v_gs), .V_DS(v_ds), .out_valid(out_valid), .out_n(out_n)
    );

    smc_seq #(.N_MOS(N_MOS), .K(K), .DW(DW), .OW(6)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready), .mode(mode),
        .W(w), .V_GS(v_gs), .V_DS(v_ds), .out_valid(sat_out_valid), .out_n(sat_out_n)
    );

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic send_beat(input int i);
        w        = fw[i];
        v_gs     = fg[i];
        v_ds     = fd[i];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic set_uniform();
        for (int i = 0; i < N_MOS; i++) begin
            fw[i] = 3'd3; fg[i] = 3'd3; fd[i] = 3'd1;
        end
    endtask

    task automatic set_scrambled();
        fg = '{3'd4, 3'd1, 3'd6, 3'd2, 3'd5, 3'd3};
        for (int i = 0; i < N_MOS; i++) begin
            fw[i] = 3'd3; fd[i] = 3'd7;
        end
    endtask

    // Sends one frame, optionally with 3 idle cycles between beats and junk beats while busy.
    task automatic run_frame(input logic [1:0] m, input bit gaps, input int expected, input string tag);
        int lat;
        bit seen;
        mode     = m;
        in_valid = 1'b0;
        for (int i = 0; i < N_MOS; i++) begin
            send_beat(i);
            if (gaps && i == 0)
                mode = 2'($urandom);
            if (gaps && i < N_MOS - 1) begin
                repeat (3) begin
                    w = DW'($urandom); v_gs = DW'($urandom); v_ds = DW'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
        end
        check({tag, "_busy_ready"}, in_ready, 0);
        if (gaps) begin
            in_valid = 1'b1;
            w = DW'($urandom); v_gs = DW'($urandom); v_ds = DW'($urandom);
        end
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                lat  = c;
                in_valid = 1'b0;
            end else if (gaps) begin
                w = DW'($urandom); v_gs = DW'($urandom); v_ds = DW'($urandom);
            end
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, lat, K + 2);
        check({tag, "_out_n"}, out_n, expected);
        @(posedge clk);
        #1;
        check({tag, "_strobe_len"}, out_valid, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit seen;
        rst = 1'b1; in_valid = 1'b0; mode = 2'b00;
        w = '0; v_gs = '0; v_ds = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_n", out_n, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_sat_in_ready", sat_in_ready, 1);

        set_uniform();
        run_frame(2'b00, 1'b0, 2, "uniform_gm");
        run_frame(2'b01, 1'b0, 3, "uniform_cur");

        set_scrambled();
        run_frame(2'b10, 1'b0, 8,  "scr_top_gm");
        run_frame(2'b00, 1'b0, 2,  "scr_bot_gm");
        run_frame(2'b11, 1'b0, 15, "scr_top_cur");
        run_frame(2'b01, 1'b0, 1,  "scr_bot_cur");
        run_frame(2'b11, 1'b1, 15, "scr_gaps");

        for (int i = 0; i < N_MOS; i++) begin
            fw[i] = 3'd7; fg[i] = 3'd7; fd[i] = 3'd7;
        end
        run_frame(2'b01, 1'b0, 84, "sat_wide");
        check("sat_narrow_out_n", sat_out_n, 63);

        // Reset after three beats of a frame whose stale entries would skew the next result.
        set_scrambled();
        mode = 2'b00;
        for (int i = 0; i < 3; i++)
            send_beat(i);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_out_n", out_n, 0);
        check("rst_mid_in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("rst_mid_no_strobe", seen, 0);
        set_uniform();
        run_frame(2'b00, 1'b0, 2, "after_rst_mid");

        // Reset lands on the edge that would raise out_valid.
        mode = 2'b01;
        for (int i = 0; i < N_MOS; i++)
            send_beat(i);
        repeat (K + 1) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_out_valid", out_valid, 0);
        check("rst_out_out_n", out_n, 0);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("rst_out_no_strobe", seen, 0);
        run_frame(2'b00, 1'b0, 2, "after_rst_out");

        for (int i = 0; i < N_MOS; i++) begin
            fw[i] = 3'd7; fg[i] = 3'd0; fd[i] = 3'd0;
        end
        fw[2] = 3'd3; fg[2] = 3'd3; fd[2] = 3'd1;
        run_frame(2'b10, 1'b0, 0, "clamp_top");
        run_frame(2'b00, 1'b0, 0, "clamp_bot");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
